// File: rtl/grf_wb_arb.sv
// grf_wb_arb: arbitrates the GRF write port between NREQ writeback
// requesters (0=ALU, 1=MEM, 2=MDU). At most one grant per cycle; the grant
// is registered and drives WE/A3/WD/PC together with a one-cycle ack pulse.
//
// Ports:
//   clk, reset        - system clock; asynchronous active-low reset
//   req               - per-requester write request, held until ack
//   a3_in/wd_in/pc_in - per-requester address (5b), data (32b), PC (32b)
//   ack               - one-hot pulse in the cycle the write reaches the GRF
//   WE/A3/WD/PC       - GRF write port (A3/WD/PC hold when idle)
//   pend              - combinational mask of registers with a pending write
//   busy              - two or more eligible requests present this cycle
//
// Build option: define GRF_WB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no rotation pointer); default is round-robin.
module grf_wb_arb #(
  parameter int unsigned NREQ = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [5*NREQ-1:0]    a3_in,
  input  logic [32*NREQ-1:0]   wd_in,
  input  logic [32*NREQ-1:0]   pc_in,
  output logic [NREQ-1:0]      ack,
  output logic                 WE,
  output logic [4:0]           A3,
  output logic [31:0]          WD,
  output logic [31:0]          PC,
  output logic [31:0]          pend,
  output logic                 busy
);

  logic [NREQ-1:0] ack_q, ack_d;
  logic            we_q, we_d;
  logic [4:0]      a3_q, a3_d;
  logic [31:0]     wd_q, wd_d;
  logic [31:0]     pc_q, pc_d;

  logic            gnt_vld;
  int unsigned     gnt_i;
  logic [4:0]      a3_sel;
  logic [31:0]     wd_sel;
  logic [31:0]     pc_sel;

`ifndef GRF_WB_FIXED_PRIO_EN
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [PW-1:0] ptr_q, ptr_d;
`endif

  // The write port is treated as occupied during an ack cycle, so a new
  // grant is only decided when no ack is being presented.
  always_comb begin : grant
    int unsigned cand;
    cand    = 0;
    gnt_vld = 1'b0;
    gnt_i   = 0;
    if (ack_q == '0) begin
`ifdef GRF_WB_FIXED_PRIO_EN
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!gnt_vld && req[i]) begin
          gnt_vld = 1'b1;
          gnt_i   = i;
        end
      end
`else
      for (int unsigned k = 0; k < NREQ; k++) begin
        cand = (32'(ptr_q) + k) % NREQ;
        if (!gnt_vld && req[cand]) begin
          gnt_vld = 1'b1;
          gnt_i   = cand;
        end
      end
`endif
    end

`ifndef GRF_WB_FIXED_PRIO_EN
    ptr_d = ptr_q;
    if (gnt_vld) begin
      ptr_d = (gnt_i == NREQ - 1) ? '0 : PW'(gnt_i + 1);
    end
`endif

    a3_sel = a3_in[5*gnt_i +: 5];
    wd_sel = wd_in[32*gnt_i +: 32];
    pc_sel = pc_in[32*gnt_i +: 32];

    ack_d = gnt_vld ? (NREQ'(1) << gnt_i) : '0;
    // Writes to r0 still consume the slot and ack, but never enable the GRF.
    we_d  = gnt_vld && (a3_sel != '0);
    a3_d  = gnt_vld ? a3_sel : a3_q;
    wd_d  = gnt_vld ? wd_sel : wd_q;
    pc_d  = gnt_vld ? pc_sel : pc_q;
  end

  always_comb begin : hazard
    int unsigned n_elig;
    n_elig = 0;
    pend   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req[i] && (a3_in[5*i +: 5] != '0)) begin
        pend[a3_in[5*i +: 5]] = 1'b1;
      end
      if (req[i] && !ack_q[i]) begin
        n_elig = n_elig + 1;
      end
    end
    busy = (n_elig >= 2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q <= '0;
      we_q  <= 1'b0;
      a3_q  <= '0;
      wd_q  <= '0;
      pc_q  <= '0;
`ifndef GRF_WB_FIXED_PRIO_EN
      ptr_q <= '0;
`endif
    end else begin
      ack_q <= ack_d;
      we_q  <= we_d;
      a3_q  <= a3_d;
      wd_q  <= wd_d;
      pc_q  <= pc_d;
`ifndef GRF_WB_FIXED_PRIO_EN
      ptr_q <= ptr_d;
`endif
    end
  end

  assign ack = ack_q;
  assign WE  = we_q;
  assign A3  = a3_q;
  assign WD  = wd_q;
  assign PC  = pc_q;

endmodule

// File: tb/tb_grf_wb_arb.sv
// Scoreboard bench for grf_wb_arb: a queue-based reference model predicts
// each grant at the clock edge it is decided; a separate monitor compares
// the DUT write port, ack, pend and busy one step after every edge.
module tb_grf_wb_arb;

  localparam int NREQ = 3;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [5*NREQ-1:0]    a3_in;
  logic [32*NREQ-1:0]   wd_in;
  logic [32*NREQ-1:0]   pc_in;
  logic [NREQ-1:0]      ack;
  logic                 WE;
  logic [4:0]           A3;
  logic [31:0]          WD;
  logic [31:0]          PC;
  logic [31:0]          pend;
  logic                 busy;

  grf_wb_arb #(.NREQ(NREQ)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .a3_in (a3_in),
    .wd_in (wd_in),
    .pc_in (pc_in),
    .ack   (ack),
    .WE    (WE),
    .A3    (A3),
    .WD    (WD),
    .PC    (PC),
    .pend  (pend),
    .busy  (busy)
  );

  typedef struct {
    logic [NREQ-1:0] ack;
    logic            we;
    logic [4:0]      a3;
    logic [31:0]     wd;
    logic [31:0]     pc;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: priority order kept as a queue; the winner moves to the
  // back. A grant occupies the port for its ack cycle, so the edge after a
  // grant never grants.
  initial begin : model
    int  order[$];
    bit  granted_last;
    int  win;
    exp_t e;
    for (int i = 0; i < NREQ; i++) order.push_back(i);
    granted_last = 0;
    forever begin
      @(posedge clk);
      if (!reset) begin
        order.delete();
        for (int i = 0; i < NREQ; i++) order.push_back(i);
        granted_last = 0;
      end else if (granted_last) begin
        granted_last = 0;
      end else begin
        win = -1;
`ifdef GRF_WB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (win < 0 && req[i]) win = i;
`else
        foreach (order[k]) if (win < 0 && req[order[k]]) win = order[k];
`endif
        if (win >= 0) begin
          e.ack = '0;
          e.ack[win] = 1'b1;
          e.a3 = a3_in[5*win +: 5];
          e.wd = wd_in[32*win +: 32];
          e.pc = pc_in[32*win +: 32];
          e.we = (e.a3 != 5'd0);
          sbq.push_back(e);
          granted_last = 1;
          while (order[0] != win) order.push_back(order.pop_front());
          order.push_back(order.pop_front());
        end
      end
    end
  end

  // Monitor: compares outputs 1 time unit after every rising edge.
  initial begin : monitor
    exp_t            e;
    logic [4:0]      last_a3;
    logic [31:0]     last_wd, last_pc, exp_pend;
    logic [NREQ-1:0] exp_ack;
    int              n_el;
    last_a3 = '0; last_wd = '0; last_pc = '0;
    forever begin
      @(posedge clk);
      #1;
      exp_ack = '0;
      if (!reset) begin
        sbq.delete();
        last_a3 = '0; last_wd = '0; last_pc = '0;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_we", 32'(WE), 32'd0);
        chk("rst_a3", 32'(A3), 32'd0);
        chk("rst_wd", WD, 32'd0);
        chk("rst_pc", PC, 32'd0);
      end else if (sbq.size() > 0) begin
        e = sbq.pop_front();
        exp_ack = e.ack;
        chk("ack", 32'(ack), 32'(e.ack));
        chk("we", 32'(WE), 32'(e.we));
        chk("a3", 32'(A3), 32'(e.a3));
        chk("wd", WD, e.wd);
        chk("pc", PC, e.pc);
        last_a3 = e.a3; last_wd = e.wd; last_pc = e.pc;
      end else begin
        chk("idle_ack", 32'(ack), 32'd0);
        chk("idle_we", 32'(WE), 32'd0);
        chk("hold_a3", 32'(A3), 32'(last_a3));
        chk("hold_wd", WD, last_wd);
        chk("hold_pc", PC, last_pc);
      end
      exp_pend = '0;
      n_el = 0;
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && a3_in[5*i +: 5] != 5'd0) exp_pend[a3_in[5*i +: 5]] = 1'b1;
        if (req[i] && !exp_ack[i]) n_el++;
      end
      chk("pend", pend, exp_pend);
      chk("busy", 32'(busy), 32'(n_el >= 2));
    end
  end

  task automatic set_payload(input int i, input logic [4:0] a3, input logic [31:0] wd,
                             input logic [31:0] pc);
    a3_in[5*i +: 5]   = a3;
    wd_in[32*i +: 32] = wd;
    pc_in[32*i +: 32] = pc;
  endtask

  // Wait (bounded) for requester i's ack, sampled at the falling edge;
  // returns in the ack cycle so the caller may drop or renew the request.
  task automatic wait_ack(input int i);
    bit seen;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (ack[i]) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL ack_timeout: requester %0d got no ack, required within 20 cycles", i);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin : stim
    bit seen;
    reset = 1'b0;
    req   = '0;
    a3_in = '0;
    wd_in = '0;
    pc_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Single write to r5.
    set_payload(0, 5'd5, 32'd10, 32'h0000_3000);
    req = 3'b001;
    wait_ack(0);
    req = '0;
    repeat (2) @(negedge clk);

    // Write to r0: acked, WE low, no pending bit.
    set_payload(0, 5'd0, 32'hdead_beef, 32'h0000_3004);
    req = 3'b001;
    #1 chk("pend_r0", pend, 32'd0);
    wait_ack(0);
    req = '0;
    repeat (2) @(negedge clk);

    // Pending mask for r7 from requester 1, cleared when req drops.
    set_payload(1, 5'd7, 32'h1234_5678, 32'h0000_3008);
    req = 3'b010;
    #1 chk("pend_r7", pend, 32'h0000_0080);
    wait_ack(1);
    req = '0;
    #1 chk("pend_clr", pend, 32'd0);

    // All three held from ptr=0.
    do_reset();
    set_payload(0, 5'd1, 32'h0000_0a0a, 32'h0000_4000);
    set_payload(1, 5'd2, 32'h0000_0b0b, 32'h0000_4004);
    set_payload(2, 5'd3, 32'h0000_0c0c, 32'h0000_4008);
    req = 3'b111;
    #1 chk("busy_3req", 32'(busy), 32'd1);
    repeat (12) @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);

    // Reset asserted in the middle of an ack cycle.
    req = 3'b011;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk);
      #2;
      if (ack != '0) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL mid_ack_timeout: got no ack, required within 10 cycles");
    end
    #1 reset = 1'b0;
    #1;
    chk("async_ack", 32'(ack), 32'd0);
    chk("async_we", 32'(WE), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_ack(0);
    req = '0;
    repeat (3) @(negedge clk);

    // Randomized traffic obeying the hold-until-ack protocol.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          if (ack[i]) begin
            if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
            else set_payload(i, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                             $urandom, $urandom);
          end
        end else if ($urandom_range(0, 2) == 0) begin
          set_payload(i, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                      $urandom, $urandom);
          req[i] = 1'b1;
        end
      end
    end
    @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
